// File: rtl/sched_datapath_seq.sv
// Microprogrammed scheduled datapath: ALU, MUL, LOG1 and LOG2 share N_REG registers and run from a loadable control store.
// Optional: define SCHED_DIV_ZERO_FLAG_EN to add a sticky div_zero_err output.

module sched_fu #(
   parameter int DATA_W = 32,
   parameter int KIND   = 0   // 0 ALU, 1 MUL, 2 LOG
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [1:0]        op_i,
   output logic [DATA_W-1:0] y_o
);
   always_comb begin
      y_o = '0;
      case (KIND)
         0: case (op_i)
               2'd0: y_o = a_i + b_i;
               2'd1: y_o = a_i - b_i;
               2'd2: y_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
               default: y_o = a_i;
            endcase
         1: case (op_i)
               2'd0: y_o = a_i * b_i;
               2'd1: y_o = (b_i == '0) ? '1 : a_i / b_i;
               2'd2: y_o = (b_i == '0) ? a_i : a_i % b_i;
               default: y_o = '0;
            endcase
         default: case (op_i)
               2'd0: y_o = a_i & b_i;
               2'd1: y_o = a_i | b_i;
               2'd2: y_o = a_i ^ b_i;
               default: y_o = ~a_i;
            endcase
      endcase
   end
endmodule

module sched_datapath_seq #(
   parameter int DATA_W  = 32,
   parameter int N_IN    = 8,
   parameter int N_REG   = 8,
   parameter int N_STEPS = 16,
   localparam int SEL_W  = $clog2(N_IN + N_REG),
   localparam int RIDX_W = $clog2(N_REG),
   localparam int FU_W   = 2*SEL_W + 2 + RIDX_W + 1,
   localparam int CW     = 4*FU_W + SEL_W + 1,
   localparam int PA_W   = $clog2(N_STEPS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_IN*DATA_W-1:0] in_bus,
   input  logic                   start,
   input  logic                   prog_we,
   input  logic [PA_W-1:0]        prog_addr,
   input  logic [CW-1:0]          prog_data,
   output logic                   busy,
   output logic [DATA_W-1:0]      result,
   output logic                   done
`ifdef SCHED_DIV_ZERO_FLAG_EN
   ,
   output logic                   div_zero_err
`endif
);
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t                          state_q;
   logic [PA_W-1:0]                 pc_q;
   logic [DATA_W-1:0]               regs_q [N_REG];
   logic [DATA_W-1:0]               regs_d [N_REG];
   logic [DATA_W-1:0]               inp_q  [N_IN];
   logic [CW-1:0]                   mem    [N_STEPS];
   logic [SEL_W-1:0]                res_sel_q;
   logic [DATA_W-1:0]               result_q;
   logic                            done_q;

   logic [CW-1:0]                   cw;
   logic [3:0][SEL_W-1:0]           sel1, sel2;
   logic [3:0][1:0]                 op;
   logic [3:0][RIDX_W-1:0]          dst;
   logic [3:0]                      wen;
   logic [3:0][DATA_W-1:0]          opa, opb, fres;
   logic [SEL_W-1:0]                res_sel;
   logic                            last;
   logic [N_IN+N_REG-1:0][DATA_W-1:0] src_all;

   // Codes past the last register select nothing and read as zero.
   function automatic logic [DATA_W-1:0] pick(input logic [SEL_W-1:0] code,
                                               input logic [N_IN+N_REG-1:0][DATA_W-1:0] tbl);
      logic [DATA_W-1:0] v;
      v = '0;
      for (int k = 0; k < N_IN+N_REG; k++)
         if (code == SEL_W'(k)) v = tbl[k];
      return v;
   endfunction

   always_comb begin
      for (int k = 0; k < N_IN; k++)  src_all[k]        = inp_q[k];
      for (int k = 0; k < N_REG; k++) src_all[N_IN + k] = regs_q[k];
   end

   assign cw      = mem[pc_q];
   assign res_sel = cw[4*FU_W +: SEL_W];
   assign last    = cw[CW-1];

   for (genvar f = 0; f < 4; f++) begin : g_fu
      assign sel1[f] = cw[f*FU_W +: SEL_W];
      assign sel2[f] = cw[f*FU_W + SEL_W +: SEL_W];
      assign op[f]   = cw[f*FU_W + 2*SEL_W +: 2];
      assign dst[f]  = cw[f*FU_W + 2*SEL_W + 2 +: RIDX_W];
      assign wen[f]  = cw[f*FU_W + FU_W - 1];
      assign opa[f]  = pick(sel1[f], src_all);
      assign opb[f]  = pick(sel2[f], src_all);
      sched_fu #(.DATA_W(DATA_W), .KIND((f < 2) ? f : 2)) u_fu (
         .a_i (opa[f]),
         .b_i (opb[f]),
         .op_i(op[f]),
         .y_o (fres[f])
      );
   end

   // Ascending FU order lets LOG2 overwrite LOG1, MUL and ALU on a shared dst.
   always_comb begin
      for (int k = 0; k < N_REG; k++) begin
         regs_d[k] = regs_q[k];
         for (int f = 0; f < 4; f++)
            if (wen[f] && dst[f] == RIDX_W'(k)) regs_d[k] = fres[f];
      end
   end

`ifdef SCHED_DIV_ZERO_FLAG_EN
   logic dz_q;
   logic dz_hit;
   assign dz_hit       = wen[1] && (op[1] == 2'd1 || op[1] == 2'd2) && (opb[1] == '0);
   assign div_zero_err = dz_q;
`endif

   // Control store has no reset so a program survives rst.
   always_ff @(posedge clk)
      if (state_q == IDLE && prog_we) mem[prog_addr] <= prog_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         res_sel_q <= '0;
         result_q  <= '0;
         done_q    <= 1'b0;
         for (int k = 0; k < N_REG; k++) regs_q[k] <= '0;
         for (int k = 0; k < N_IN; k++)  inp_q[k]  <= '0;
`ifdef SCHED_DIV_ZERO_FLAG_EN
         dz_q      <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               for (int k = 0; k < N_IN; k++) inp_q[k] <= in_bus[k*DATA_W +: DATA_W];
               pc_q    <= '0;
               state_q <= RUN;
`ifdef SCHED_DIV_ZERO_FLAG_EN
               dz_q    <= 1'b0;
`endif
            end
            RUN: begin
               for (int k = 0; k < N_REG; k++) regs_q[k] <= regs_d[k];
`ifdef SCHED_DIV_ZERO_FLAG_EN
               if (dz_hit) dz_q <= 1'b1;
`endif
               if (last || pc_q == PA_W'(N_STEPS-1)) begin
                  res_sel_q <= res_sel;
                  state_q   <= FIN;
               end else begin
                  pc_q <= pc_q + 1'b1;
               end
            end
            FIN: begin
               result_q <= pick(res_sel_q, src_all);
               done_q   <= 1'b1;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy   = (state_q != IDLE);
   assign result = result_q;
   assign done   = done_q;
endmodule

// File: tb/tb_sched_datapath_seq.sv
// Directed plus randomized bench for sched_datapath_seq against a step-level program model.
// Covers the SCHED_DIV_ZERO_FLAG_EN output when that macro is defined.

module tb_sched_datapath_seq;
   localparam int DATA_W  = 32;
   localparam int N_IN    = 8;
   localparam int N_REG   = 8;
   localparam int N_STEPS = 16;
   localparam int SEL_W   = $clog2(N_IN + N_REG);
   localparam int RIDX_W  = $clog2(N_REG);
   localparam int FU_W    = 2*SEL_W + 2 + RIDX_W + 1;
   localparam int CW      = 4*FU_W + SEL_W + 1;
   localparam int PA_W    = $clog2(N_STEPS);

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic [N_IN*DATA_W-1:0] in_bus = '0;
   logic                   start = 1'b0;
   logic                   prog_we = 1'b0;
   logic [PA_W-1:0]        prog_addr = '0;
   logic [CW-1:0]          prog_data = '0;
   logic                   busy;
   logic [DATA_W-1:0]      result;
   logic                   done;
`ifdef SCHED_DIV_ZERO_FLAG_EN
   logic                   div_zero_err;
`endif

   sched_datapath_seq #(.DATA_W(DATA_W), .N_IN(N_IN), .N_REG(N_REG), .N_STEPS(N_STEPS)) dut (
      .clk(clk), .rst(rst), .in_bus(in_bus), .start(start), .prog_we(prog_we),
      .prog_addr(prog_addr), .prog_data(prog_data), .busy(busy), .result(result), .done(done)
`ifdef SCHED_DIV_ZERO_FLAG_EN
      , .div_zero_err(div_zero_err)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Program held as fields per step and FU (0 ALU, 1 MUL, 2 LOG1, 3 LOG2).
   int p_s1 [N_STEPS][4], p_s2 [N_STEPS][4], p_op [N_STEPS][4], p_dst [N_STEPS][4], p_wen [N_STEPS][4];
   int p_rs [N_STEPS], p_last [N_STEPS];
   logic [DATA_W-1:0] m_in [N_IN];
   logic [DATA_W-1:0] m_regs [N_REG];
   logic [DATA_W-1:0] m_result;
   bit                m_dz;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CW-1:0] enc(input int a);
      logic [CW-1:0] w;
      w = '0;
      for (int f = 0; f < 4; f++) begin
         w[f*FU_W +: SEL_W]                = SEL_W'(p_s1[a][f]);
         w[f*FU_W + SEL_W +: SEL_W]        = SEL_W'(p_s2[a][f]);
         w[f*FU_W + 2*SEL_W +: 2]          = 2'(p_op[a][f]);
         w[f*FU_W + 2*SEL_W + 2 +: RIDX_W] = RIDX_W'(p_dst[a][f]);
         w[f*FU_W + FU_W - 1]              = (p_wen[a][f] != 0);
      end
      w[4*FU_W +: SEL_W] = SEL_W'(p_rs[a]);
      w[CW-1]            = (p_last[a] != 0);
      return w;
   endfunction

   function automatic logic [DATA_W-1:0] src(input int c);
      if (c < N_IN) return m_in[c];
      if (c < N_IN + N_REG) return m_regs[c - N_IN];
      return '0;
   endfunction

   function automatic logic [DATA_W-1:0] fu_eval(input int f, input int op,
                                                 input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] y;
      if (f == 0)
         y = (op == 0) ? a + b : (op == 1) ? a - b : (op == 2) ? ((a < b) ? 1 : 0) : a;
      else if (f == 1)
         y = (op == 0) ? a * b : (op == 1) ? ((b == 0) ? 32'hFFFF_FFFF : a / b)
           : (op == 2) ? ((b == 0) ? a : a % b) : 0;
      else
         y = (op == 0) ? (a & b) : (op == 1) ? (a | b) : (op == 2) ? (a ^ b) : ~a;
      return y;
   endfunction

   task automatic model_run(output int n, output logic [DATA_W-1:0] res, output bit dz);
      logic [DATA_W-1:0] y [4];
      logic [DATA_W-1:0] a, b;
      int pc = 0;
      m_dz = 0;
      while (1) begin
         for (int f = 0; f < 4; f++) begin
            a = src(p_s1[pc][f]);
            b = src(p_s2[pc][f]);
            y[f] = fu_eval(f, p_op[pc][f], a, b);
            if (f == 1 && p_wen[pc][f] != 0 && (p_op[pc][f] == 1 || p_op[pc][f] == 2) && b == 0) m_dz = 1;
         end
         for (int f = 0; f < 4; f++)
            if (p_wen[pc][f] != 0) m_regs[p_dst[pc][f]] = y[f];
         if (p_last[pc] != 0 || pc == N_STEPS-1) break;
         pc++;
      end
      n        = pc + 1;
      m_result = src(p_rs[pc]);
      res      = m_result;
      dz       = m_dz;
   endtask

   task automatic clrstep(input int a);
      for (int f = 0; f < 4; f++) begin
         p_s1[a][f] = 0; p_s2[a][f] = 0; p_op[a][f] = 0; p_dst[a][f] = 0; p_wen[a][f] = 0;
      end
      p_rs[a] = 0;
      p_last[a] = 0;
   endtask

   task automatic setfu(input int a, input int f, input int s1, input int s2, input int op, input int d, input int w);
      p_s1[a][f] = s1; p_s2[a][f] = s2; p_op[a][f] = op; p_dst[a][f] = d; p_wen[a][f] = w;
   endtask

   task automatic prog(input int a);
      prog_we   = 1'b1;
      prog_addr = PA_W'(a);
      prog_data = enc(a);
      tick();
      prog_we   = 1'b0;
   endtask

   task automatic drive_in();
      for (int k = 0; k < N_IN; k++) in_bus[k*DATA_W +: DATA_W] = m_in[k];
   endtask

   task automatic run(input string tag, input bit noise, input bit wprog, input bit chg);
      int n, got, bcnt;
      logic [DATA_W-1:0] res;
      bit dz;
      model_run(n, res, dz);
      drive_in();
      start = 1'b1;
      if (wprog) begin
         prog_we = 1'b1; prog_addr = '0; prog_data = enc(0);
      end
      tick();
      start = 1'b0; prog_we = 1'b0;
      if (chg) in_bus = {N_IN{32'd9}};
`ifdef SCHED_DIV_ZERO_FLAG_EN
      chk({tag, "_dzclr"}, div_zero_err, 0);
`endif
      got = 0; bcnt = 0;
      for (int e = 1; e <= 40; e++) begin
         if (busy) bcnt++;
         if (noise && (e == 2 || e == 5)) begin
            start = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_data = '1;
         end
         tick();
         start = 1'b0; prog_we = 1'b0;
         if (done) begin got = e; break; end
      end
      chk({tag, "_lat"}, got, n + 1);
      chk({tag, "_busy"}, bcnt, n + 1);
      chk({tag, "_res"}, result, res);
`ifdef SCHED_DIV_ZERO_FLAG_EN
      chk({tag, "_dz"}, div_zero_err, dz);
`endif
      tick();
      chk({tag, "_donedrop"}, done, 0);
      chk({tag, "_hold"}, result, res);
   endtask

   task automatic load_t1();
      clrstep(0); clrstep(1);
      setfu(0, 0, 0, 1, 0, 0, 1);
      setfu(0, 1, 2, 3, 0, 1, 1);
      setfu(1, 0, N_IN+1, N_IN+0, 1, 2, 1);
      p_last[1] = 1; p_rs[1] = N_IN + 2;
      prog(0); prog(1);
      for (int k = 0; k < N_IN; k++) m_in[k] = '0;
      m_in[0] = 5; m_in[1] = 7; m_in[2] = 6; m_in[3] = 4;
   endtask

   initial begin
      for (int k = 0; k < N_REG; k++) m_regs[k] = '0;
      for (int k = 0; k < N_IN; k++) m_in[k] = '0;
      m_result = '0; m_dz = 0;
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
`ifdef SCHED_DIV_ZERO_FLAG_EN
      chk("rst_dz", div_zero_err, 0);
`endif
      rst = 1'b1;
      tick();

      load_t1();
      run("t1", 0, 0, 0);
      chk("t1_const", result, 32'd12);
      run("t2", 0, 0, 1);
      chk("t2_const", result, 32'd12);

      clrstep(0);
      setfu(0, 0, 0, 0, 3, 3, 1);
      setfu(0, 3, 1, 1, 1, 3, 1);
      p_last[0] = 1; p_rs[0] = N_IN + 3;
      prog(0);
      m_in[0] = 1; m_in[1] = 2;
      run("t3", 0, 0, 0);
      chk("t3_const", result, 32'd2);

      clrstep(0);
      setfu(0, 1, 0, 1, 1, 0, 1);
      p_last[0] = 1; p_rs[0] = N_IN + 0;
      prog(0);
      m_in[0] = 100; m_in[1] = 0;
      run("t4", 0, 0, 0);
      chk("t4_const", result, 32'hFFFF_FFFF);
      tick(); tick();
`ifdef SCHED_DIV_ZERO_FLAG_EN
      chk("t4_dz_sticky", div_zero_err, 1);
`endif

      for (int a = 0; a < N_STEPS; a++) begin
         clrstep(a);
         setfu(a, 0, N_IN+0, 0, 0, 0, 1);
         p_rs[a] = N_IN + 0;
         prog(a);
      end
      m_in[0] = 3;
      run("t5", 1, 0, 0);
      run("t5_readback", 0, 0, 0);

      load_t1();
      drive_in();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_done", done, 0);
      chk("t6_result", result, 0);
`ifdef SCHED_DIV_ZERO_FLAG_EN
      chk("t6_dz", div_zero_err, 0);
`endif
      for (int k = 0; k < N_REG; k++) m_regs[k] = '0;
      m_result = '0; m_dz = 0;
      tick();
      rst = 1'b1;
      tick();
      run("t6_rerun", 0, 0, 0);
      chk("t6_const", result, 32'd12);

      for (int it = 0; it < 20; it++) begin
         int len;
         bit wp;
         len = $urandom_range(1, 4);
         wp  = 1'($urandom_range(0, 1));
         for (int s = 0; s < len; s++) begin
            clrstep(s);
            for (int f = 0; f < 4; f++)
               setfu(s, f, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
                     $urandom_range(0, N_REG-1), $urandom_range(0, 1));
            p_rs[s]   = $urandom_range(0, 15);
            p_last[s] = (s == len - 1) ? 1 : 0;
            if (!(wp && s == 0)) prog(s);
         end
         for (int k = 0; k < N_IN; k++)
            m_in[k] = ($urandom_range(0, 2) == 0) ? '0 :
                      ($urandom_range(0, 1) != 0) ? DATA_W'($urandom_range(0, 50)) : $urandom;
         run("rnd", 0, wp, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sched_datapath_seq.md
Name: sched_datapath_seq

Overview:
- Parametrised successor to the fixed scheduled datapaths; the schedule is a loadable microprogram instead of hard-wired selects and enables.
- Integrates its own controller and a start/done handshake.
- Four functional units (ALU, MUL, LOG1, LOG2) share N_REG intermediate registers.
- Operands come from a captured copy of N_IN inputs or from the intermediate registers; one result register is exposed.

Parameters:
- DATA_W, 32, operand/result width.
- N_IN, 8, number of input operands.
- N_REG, 8, number of intermediate registers.
- N_STEPS, 16, microprogram depth (max control steps).
- Localparams: SEL_W = clog2(N_IN+N_REG); RIDX_W = clog2(N_REG); FU_W = 2*SEL_W+2+RIDX_W+1; CW = 4*FU_W+SEL_W+1; PA_W = clog2(N_STEPS).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_bus  in  N_IN*DATA_W  operand k at [k*DATA_W +: DATA_W].
- start  in  1  run request.
- prog_we  in  1  microprogram write strobe.
- prog_addr  in  PA_W  step address.
- prog_data  in  CW  control word.
- busy  out  1  high in RUN and FIN.
- result  out  DATA_W  registered result.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Control word layout, LSB first:
  - Per FU, order ALU, MUL, LOG1, LOG2: sel1, sel2, op[1:0], dst[RIDX_W-1:0], wen.
  - Then res_sel[SEL_W-1:0], then last.
- Select codes: 0..N_IN-1 select the captured input; N_IN..N_IN+N_REG-1 select register (code-N_IN); other codes give 0.
- ALU op:
  - 0 add, 1 sub (mod 2^DATA_W).
  - 2 unsigned less-than (1/0).
  - 3 pass sel1.
- MUL op:
  - 0 product, low DATA_W bits.
  - 1 unsigned divide; divisor 0 gives all-ones.
  - 2 unsigned modulo; divisor 0 gives the dividend.
  - 3 gives 0.
- LOG op: 0 AND, 1 OR, 2 XOR, 3 NOT sel1.
- FSM states IDLE, RUN, FIN.
- IDLE:
  - start=1 captures in_bus into the input copy, sets pc=0, moves to RUN.
  - prog_we=1 writes prog_data into mem[prog_addr]. If prog_we and start are both high, the write happens and the run starts with the newly written contents.
- RUN:
  - Each cycle executes mem[pc]; every FU with wen=1 writes its output to reg[dst] at the edge.
  - Same-step write to the same dst: priority LOG2 > LOG1 > MUL > ALU.
  - Operands read pre-edge register values; no bypass within a step.
  - If last=1 or pc=N_STEPS-1: latch res_sel, go to FIN. Otherwise pc+1.
- FIN:
  - At the edge, result <= source(latched res_sel) using post-last-step register values.
  - done <= 1, state goes to IDLE.
  - done drops the following edge.
- Latency: for n executed steps, done is high after edge n+1 counted from the start-sampling edge (edge 0). Minimum n=1 gives done after edge 2.
- Ignored inputs:
  - start while busy is ignored.
  - prog_we while busy is ignored, with no effect on mem.
  - in_bus changes after capture do not affect the run.
- Result holds its value until the next FIN.
- Reset (rst=0, any time including mid-run):
  - state=IDLE, pc=0, registers=0, input copy=0, result=0, done=0, busy=0.
  - Microprogram memory is not reset and keeps its contents.
  - First start after release behaves normally.

Optional Feature:
- Macro SCHED_DIV_ZERO_FLAG_EN.
- Defined:
  - Adds output div_zero_err (1 bit, reset 0).
  - Set to 1 at any RUN edge where MUL executes op 1 or 2 with a zero divisor and the MUL wen=1.
  - Sticky until the next accepted start, which clears it.
  - Visible together with done.
- Undefined: the port and the logic are absent; division results are unchanged.

Test Plan:
- Program step0: ALU add in0+in1->r0, MUL mul in2*in3->r1. Program step1: ALU sub r1-r0->r2, last=1, res_sel=r2. Inputs 5,7,6,4 -> done after edge 3, result=12, busy high for 3 cycles.
- Same program, change in_bus to all 9s the cycle after start -> result still 12.
- Step0: ALU pass in0->r3 and LOG2 OR in1|in1->r3, last, res_sel=r3. in0=1, in1=2 -> result=2 (LOG2 wins).
- MUL div in0/in1->r0 with in1=0, in0=100, res_sel=r0 -> result=32'hFFFFFFFF; with macro defined, div_zero_err=1 until the next start.
- Program with no last bit set -> runs all 16 steps, done after edge 17. start pulses during the run are ignored, and a prog_we during the run leaves mem unchanged on readback run.
- Assert rst=0 mid-run at step 1 -> busy, done, and result are 0 immediately. Rerun after release without reprogramming -> original result 12.
